// File: rtl/axi_mem_slave_128bit.sv
// AXI4 INCR-burst memory responder with 128-bit data and a word-addressed internal RAM.
// Write (AW/W/B) and read (AR/R) paths are independent, one outstanding burst each.
module axi_mem_slave_128bit #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter bit          INIT_ZERO  = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  axi_awaddr,
  input  logic [7:0]   axi_awlen,
  input  logic [2:0]   axi_awsize,
  input  logic [1:0]   axi_awburst,
  input  logic         axi_awvalid,
  output logic         axi_awready,
  input  logic [127:0] axi_wdata,
  input  logic [15:0]  axi_wstrb,
  input  logic         axi_wvalid,
  input  logic         axi_wlast,
  output logic         axi_wready,
  output logic [1:0]   axi_bresp,
  output logic         axi_bvalid,
  input  logic         axi_bready,
  input  logic [31:0]  axi_araddr,
  input  logic [7:0]   axi_arlen,
  input  logic [2:0]   axi_arsize,
  input  logic [1:0]   axi_arburst,
  input  logic         axi_arvalid,
  output logic         axi_arready,
  output logic [127:0] axi_rdata,
  output logic [1:0]   axi_rresp,
  output logic         axi_rvalid,
  output logic         axi_rlast,
  input  logic         axi_rready
);

  localparam int unsigned Depth  = 1 << DEPTH_LOG2;
  localparam int unsigned AddrHi = DEPTH_LOG2 + 3;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlverr = 2'b10;

  typedef logic [DEPTH_LOG2-1:0] idx_t;
  typedef enum logic [1:0] {StWIdle, StWData, StWResp} w_state_e;
  typedef enum logic [1:0] {StRIdle, StRFetch, StRData} r_state_e;

  // Power-up contents come from the simulator or bitstream default; reset never touches them.
  logic [127:0] mem [Depth];

  // Byte offset and address bits above the array wrap are ignored by design.
  logic unused_bits;
  assign unused_bits = ^{axi_awaddr[31:AddrHi+1], axi_awaddr[3:0],
                         axi_araddr[31:AddrHi+1], axi_araddr[3:0], INIT_ZERO};

  // ---------------------------------------------------------------- write path
  w_state_e    w_state_q, w_state_d;
  idx_t        w_idx_q, w_idx_d;
  logic [7:0]  w_len_q, w_len_d;
  logic [7:0]  w_beat_q, w_beat_d;
  logic        w_err_q, w_err_d;
  logic        awready_q, wready_q, bvalid_q;
  logic [1:0]  bresp_q, bresp_d;
  logic        mem_we;
  logic        w_last;

  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_err_d   = w_err_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    w_last    = 1'b0;
    unique case (w_state_q)
      StWIdle: begin
        if (axi_awvalid && awready_q) begin
          w_idx_d   = axi_awaddr[AddrHi:4];
          w_len_d   = axi_awlen;
          w_beat_d  = 8'd0;
          w_err_d   = (axi_awburst != 2'd1) || (axi_awsize != 3'b100);
          w_state_d = StWData;
        end
      end
      StWData: begin
        if (axi_wvalid && wready_q) begin
          w_last   = (w_beat_q == w_len_q);
          mem_we   = !w_err_q;
          w_idx_d  = w_idx_q + idx_t'(1);
          w_beat_d = w_beat_q + 8'd1;
          // The beat count ends the burst; a disagreeing wlast only flags an error.
          if (axi_wlast != w_last) w_err_d = 1'b1;
          if (w_last) begin
            w_state_d = StWResp;
            bresp_d   = w_err_d ? RespSlverr : RespOkay;
          end
        end
      end
      StWResp: begin
        if (axi_bready && bvalid_q) begin
          w_state_d = StWIdle;
          bresp_d   = RespOkay;
        end
      end
      default: w_state_d = StWIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= StWIdle;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_err_q   <= w_err_d;
      awready_q <= (w_state_d == StWIdle);
      wready_q  <= (w_state_d == StWData);
      bvalid_q  <= (w_state_d == StWResp);
      bresp_q   <= bresp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 16; i++) begin
        if (axi_wstrb[i]) mem[w_idx_q][8*i +: 8] <= axi_wdata[8*i +: 8];
      end
    end
  end

  assign axi_awready = awready_q;
  assign axi_wready  = wready_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bresp   = bresp_q;

  // ----------------------------------------------------------------- read path
  r_state_e     r_state_q, r_state_d;
  idx_t         r_idx_q, r_idx_d;    // index of the next word to load
  logic [7:0]   r_len_q, r_len_d;
  logic [7:0]   r_beat_q, r_beat_d;  // beat number currently presented
  logic         r_err_q, r_err_d;
  logic         arready_q;
  logic         rvalid_q, rvalid_d;
  logic         rlast_q, rlast_d;
  logic [1:0]   rresp_q, rresp_d;
  logic [127:0] rdata_q, rdata_d;

  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_err_d   = r_err_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    unique case (r_state_q)
      StRIdle: begin
        if (axi_arvalid && arready_q) begin
          r_idx_d   = axi_araddr[AddrHi:4];
          r_len_d   = axi_arlen;
          r_err_d   = (axi_arburst != 2'd1) || (axi_arsize != 3'b100);
          r_state_d = StRFetch;
        end
      end
      StRFetch: begin
        rvalid_d  = 1'b1;
        rdata_d   = r_err_q ? '0 : mem[r_idx_q];
        rresp_d   = r_err_q ? RespSlverr : RespOkay;
        rlast_d   = (r_len_q == 8'd0);
        r_beat_d  = 8'd0;
        r_idx_d   = r_idx_q + idx_t'(1);
        r_state_d = StRData;
      end
      StRData: begin
        if (rvalid_q && axi_rready) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            r_state_d = StRIdle;
          end else begin
            rdata_d  = r_err_q ? '0 : mem[r_idx_q];
            r_idx_d  = r_idx_q + idx_t'(1);
            r_beat_d = r_beat_q + 8'd1;
            rlast_d  = (r_beat_d == r_len_q);
          end
        end
      end
      default: r_state_d = StRIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= StRIdle;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_err_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RespOkay;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_err_q   <= r_err_d;
      arready_q <= (r_state_d == StRIdle);
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign axi_arready = arready_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rlast   = rlast_q;
  assign axi_rresp   = rresp_q;
  assign axi_rdata   = rdata_q;

endmodule

// File: tb/tb_axi_mem_slave_128bit.sv
// Self-checking bench for axi_mem_slave_128bit: directed scenarios plus randomized
// concurrent bursts, all checked against a word-array memory model.
module tb_axi_mem_slave_128bit;
  localparam int DL = 10;
  localparam int D  = 1 << DL;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  axi_awaddr = '0;
  logic [7:0]   axi_awlen = '0;
  logic [2:0]   axi_awsize = '0;
  logic [1:0]   axi_awburst = '0;
  logic         axi_awvalid = 1'b0;
  logic         axi_awready;
  logic [127:0] axi_wdata = '0;
  logic [15:0]  axi_wstrb = '0;
  logic         axi_wvalid = 1'b0;
  logic         axi_wlast = 1'b0;
  logic         axi_wready;
  logic [1:0]   axi_bresp;
  logic         axi_bvalid;
  logic         axi_bready = 1'b0;
  logic [31:0]  axi_araddr = '0;
  logic [7:0]   axi_arlen = '0;
  logic [2:0]   axi_arsize = '0;
  logic [1:0]   axi_arburst = '0;
  logic         axi_arvalid = 1'b0;
  logic         axi_arready;
  logic [127:0] axi_rdata;
  logic [1:0]   axi_rresp;
  logic         axi_rvalid;
  logic         axi_rlast;
  logic         axi_rready = 1'b0;

  always #5 clk = ~clk;

  axi_mem_slave_128bit #(.DEPTH_LOG2(DL), .INIT_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
    .axi_wlast(axi_wlast), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
    .axi_rlast(axi_rlast), .axi_rready(axi_rready)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain word array plus a flag for words whose full value is known.
  logic [127:0] mdl [D];
  bit           known [D];

  typedef struct {
    logic [127:0] data;
    logic [1:0]   resp;
    logic         last;
    bit           dk;
  } rexp_t;
  rexp_t      rq[$];
  logic [1:0] bq[$];

  logic [127:0] wd [256];
  logic [15:0]  ws [256];
  logic [127:0] rd_got [256];
  logic [1:0]   rd_resp [256];
  logic [1:0]   last_bresp;
  int           pat [7] = '{1, 0, 0, 1, 1, 0, 1};
  bit           mon_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Compare process: every R and B handshake against the model, plus hold rules.
  bit           r_hold = 1'b0;
  logic [127:0] h_data;
  logic [1:0]   h_resp;
  logic         h_last;
  bit           b_hold = 1'b0;
  logic [1:0]   h_bresp;
  rexp_t        m_e;
  logic [1:0]   m_b;

  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      r_hold = 1'b0;
      b_hold = 1'b0;
    end else begin
      if (r_hold) begin
        chk("r_hold_valid", 128'(axi_rvalid), 128'd1);
        chk("r_hold_data", axi_rdata, h_data);
        chk("r_hold_resp", 128'(axi_rresp), 128'(h_resp));
        chk("r_hold_last", 128'(axi_rlast), 128'(h_last));
      end
      if (axi_rvalid && axi_rready) begin
        chk("r_beat_expected", 128'(rq.size() > 0), 128'd1);
        if (rq.size() > 0) begin
          m_e = rq.pop_front();
          if (m_e.dk) chk("r_data", axi_rdata, m_e.data);
          chk("r_resp", 128'(axi_rresp), 128'(m_e.resp));
          chk("r_last", 128'(axi_rlast), 128'(m_e.last));
        end
      end
      r_hold = axi_rvalid && !axi_rready;
      h_data = axi_rdata;
      h_resp = axi_rresp;
      h_last = axi_rlast;
      if (b_hold) begin
        chk("b_hold_valid", 128'(axi_bvalid), 128'd1);
        chk("b_hold_resp", 128'(axi_bresp), 128'(h_bresp));
      end
      if (axi_bvalid) chk("b_awready_low", 128'(axi_awready), 128'd0);
      if (axi_bvalid && axi_bready) begin
        chk("b_expected", 128'(bq.size() > 0), 128'd1);
        if (bq.size() > 0) begin
          m_b = bq.pop_front();
          chk("b_resp", 128'(axi_bresp), 128'(m_b));
        end
      end
      b_hold  = axi_bvalid && !axi_bready;
      h_bresp = axi_bresp;
    end
  end

  task automatic model_write(input int idx, input logic [127:0] d, input logic [15:0] s);
    for (int k = 0; k < 16; k++) if (s[k]) mdl[idx][8*k +: 8] = d[8*k +: 8];
    if (s == 16'hFFFF) known[idx] = 1'b1;
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input int bdly);
    int n;
    int idx;
    bit err;
    idx = int'(addr[DL+3:4]);
    err = (burst != 2'd1) || (size != 3'b100);
    @(posedge clk); #1;
    axi_awaddr = addr; axi_awlen = len[7:0]; axi_awsize = size; axi_awburst = burst;
    axi_awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi_awready && n < 100) begin @(negedge clk); n++; end
    chk("aw_accept", 128'(axi_awready), 128'd1);
    @(posedge clk); #1;
    axi_awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      axi_wvalid = 1'b1; axi_wdata = wd[b]; axi_wstrb = ws[b]; axi_wlast = (b == len);
      n = 0;
      @(negedge clk);
      while (!axi_wready && n < 100) begin @(negedge clk); n++; end
      chk("w_accept", 128'(axi_wready), 128'd1);
      if (!err) model_write(idx, wd[b], ws[b]);
      idx = (idx + 1) % D;
      @(posedge clk); #1;
    end
    axi_wvalid = 1'b0; axi_wlast = 1'b0;
    bq.push_back(err ? 2'b10 : 2'b00);
    if (bdly > 0) begin
      repeat (bdly) @(posedge clk);
      #1;
    end
    axi_bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi_bvalid && n < 100) begin @(negedge clk); n++; end
    chk("b_seen", 128'(axi_bvalid), 128'd1);
    last_bresp = axi_bresp;
    @(posedge clk); #1;
    axi_bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                         input logic [1:0] burst, input int mode);
    int n;
    int idx;
    int beats;
    int k;
    bit err;
    rexp_t e;
    idx = int'(addr[DL+3:4]);
    err = (burst != 2'd1) || (size != 3'b100);
    @(posedge clk); #1;
    axi_araddr = addr; axi_arlen = len[7:0]; axi_arsize = size; axi_arburst = burst;
    axi_arvalid = 1'b1; axi_rready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!axi_arready && n < 100) begin @(negedge clk); n++; end
    chk("ar_accept", 128'(axi_arready), 128'd1);
    for (int b = 0; b <= len; b++) begin
      e.data = err ? '0 : mdl[(idx + b) % D];
      e.dk   = err || known[(idx + b) % D];
      e.resp = err ? 2'b10 : 2'b00;
      e.last = (b == len);
      rq.push_back(e);
    end
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    @(negedge clk);
    chk("r_lat_gap", 128'(axi_rvalid), 128'd0);
    beats = 0;
    k = 0;
    while (beats <= len && k < 400) begin
      @(posedge clk); #1;
      case (mode)
        0:       axi_rready = 1'b1;
        1:       axi_rready = (k < 7) ? pat[k][0] : 1'b1;
        default: axi_rready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (k == 0) chk("r_lat_first", 128'(axi_rvalid), 128'd1);
      if (axi_rvalid && axi_rready) begin
        rd_got[beats]  = axi_rdata;
        rd_resp[beats] = axi_rresp;
        beats++;
      end
      k++;
    end
    chk("r_beats", 128'(beats), 128'(len + 1));
    if (beats <= len) rq.delete();
    @(posedge clk); #1;
    axi_rready = 1'b0;
    @(negedge clk);
    chk("r_done", 128'(axi_rvalid), 128'd0);
  endtask

  task automatic rand_write(input int lo, input int span);
    int len;
    int idx;
    logic [1:0] burst;
    len = $urandom_range(0, 15);
    idx = lo + $urandom_range(0, span - len - 1);
    burst = ($urandom_range(0, 7) == 0) ? 2'd2 : 2'd1;
    for (int b = 0; b <= len; b++) begin
      wd[b] = {$urandom, $urandom, $urandom, $urandom};
      ws[b] = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'hFFFF;
    end
    do_write(($urandom & 32'hFFFF_C000) | (idx << 4) | ($urandom & 32'hF), len, 3'b100, burst,
             $urandom_range(0, 3));
  endtask

  task automatic rand_read(input int lo, input int span);
    int len;
    int idx;
    logic [2:0] size;
    len = $urandom_range(0, 15);
    idx = lo + $urandom_range(0, span - len - 1);
    size = ($urandom_range(0, 7) == 0) ? 3'b011 : 3'b100;
    do_read(($urandom & 32'hFFFF_C000) | (idx << 4) | ($urandom & 32'hF), len, size, 2'd1, 2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a_pat [8];
    logic [127:0] b_pat [8];
    int n;

    // Reset values, and awready rising one cycle after release.
    repeat (2) @(negedge clk);
    chk("rst_awready", 128'(axi_awready), 128'd0);
    chk("rst_wready", 128'(axi_wready), 128'd0);
    chk("rst_bvalid", 128'(axi_bvalid), 128'd0);
    chk("rst_bresp", 128'(axi_bresp), 128'd0);
    chk("rst_arready", 128'(axi_arready), 128'd0);
    chk("rst_rvalid", 128'(axi_rvalid), 128'd0);
    chk("rst_rlast", 128'(axi_rlast), 128'd0);
    chk("rst_rresp", 128'(axi_rresp), 128'd0);
    chk("rst_rdata", axi_rdata, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("awready_first_cycle", 128'(axi_awready), 128'd0);
    @(negedge clk);
    chk("awready_second_cycle", 128'(axi_awready), 128'd1);

    // 1: 8-beat write then back-to-back read.
    for (int b = 0; b < 8; b++) begin wd[b] = 128'(b); ws[b] = 16'hFFFF; end
    do_write(32'h0000_0100, 7, 3'b100, 2'd1, 0);
    chk("t1_bresp", 128'(last_bresp), 128'd0);
    do_read(32'h0000_0100, 7, 3'b100, 2'd1, 0);
    for (int b = 0; b < 8; b++) chk("t1_rdata", rd_got[b], 128'(b));
    chk("t1_model_pin", mdl[16 + 5], 128'd5);

    // 2: byte strobes.
    wd[0] = '1; ws[0] = 16'hFFFF;
    do_write(32'h0000_0200, 0, 3'b100, 2'd1, 0);
    wd[0] = '0; ws[0] = 16'h00F0;
    do_write(32'h0000_0200, 0, 3'b100, 2'd1, 0);
    do_read(32'h0000_0200, 0, 3'b100, 2'd1, 0);
    chk("t2_rdata", rd_got[0], 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_FFFF_FFFF);
    chk("t2_model_pin", mdl[32], 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_FFFF_FFFF);

    // 3: wrap from the last word.
    for (int b = 0; b < 4; b++) begin wd[b] = {4{32'h3000 + 32'(b)}}; ws[b] = 16'hFFFF; end
    do_write(32'h0000_3FF0, 3, 3'b100, 2'd1, 0);
    do_read(32'h0000_3FF0, 3, 3'b100, 2'd1, 0);
    for (int b = 0; b < 4; b++) chk("t3_rdata", rd_got[b], {4{32'h3000 + 32'(b)}});
    do_read(32'h8000_4000, 0, 3'b100, 2'd1, 0);
    chk("t3_alias_idx0", rd_got[0], {4{32'h3001}});
    chk("t3_model_pin", mdl[2], {4{32'h3003}});

    // 4: illegal burst type and size.
    for (int b = 0; b < 2; b++) begin wd[b] = '1; ws[b] = 16'hFFFF; end
    do_write(32'h0000_0100, 1, 3'b100, 2'd2, 0);
    chk("t4_bresp", 128'(last_bresp), 128'h2);
    do_read(32'h0000_0100, 1, 3'b100, 2'd1, 0);
    chk("t4_unchanged0", rd_got[0], 128'd0);
    chk("t4_unchanged1", rd_got[1], 128'd1);
    do_read(32'h0000_0100, 1, 3'b011, 2'd1, 0);
    for (int b = 0; b < 2; b++) begin
      chk("t4_rresp", 128'(rd_resp[b]), 128'h2);
      chk("t4_rdata", rd_got[b], 128'd0);
    end

    // 5: rready stalls and a held B response.
    do_read(32'h0000_0100, 3, 3'b100, 2'd1, 1);
    for (int b = 0; b < 4; b++) chk("t5_order", rd_got[b], 128'(b));
    wd[0] = 128'h5555; ws[0] = 16'hFFFF;
    do_write(32'h0000_0600, 0, 3'b100, 2'd1, 5);

    // 6: reset during beat 2 of an 8-beat write.
    for (int b = 0; b < 8; b++) begin
      a_pat[b] = {4{32'hA000 + 32'(b)}}; b_pat[b] = {4{32'hB000 + 32'(b)}};
      wd[b] = a_pat[b]; ws[b] = 16'hFFFF;
    end
    do_write(32'h0000_0800, 7, 3'b100, 2'd1, 0);
    @(posedge clk); #1;
    axi_awaddr = 32'h0000_0800; axi_awlen = 8'd7; axi_awsize = 3'b100; axi_awburst = 2'd1;
    axi_awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi_awready && n < 100) begin @(negedge clk); n++; end
    chk("t6_aw_accept", 128'(axi_awready), 128'd1);
    @(posedge clk); #1;
    axi_awvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      axi_wvalid = 1'b1; axi_wdata = b_pat[b]; axi_wstrb = 16'hFFFF; axi_wlast = 1'b0;
      @(negedge clk);
      chk("t6_w_accept", 128'(axi_wready), 128'd1);
      model_write(128 + b, b_pat[b], 16'hFFFF);
      @(posedge clk); #1;
    end
    axi_wdata = b_pat[2];
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_wready", 128'(axi_wready), 128'd0);
    chk("t6_rst_awready", 128'(axi_awready), 128'd0);
    chk("t6_rst_bvalid", 128'(axi_bvalid), 128'd0);
    chk("t6_rst_arready", 128'(axi_arready), 128'd0);
    chk("t6_rst_rvalid", 128'(axi_rvalid), 128'd0);
    axi_wvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t6_no_bvalid", 128'(axi_bvalid), 128'd0);
    end
    do_read(32'h0000_0800, 7, 3'b100, 2'd1, 0);
    chk("t6_kept_b1", rd_got[1], b_pat[1]);
    chk("t6_old_a2", rd_got[2], a_pat[2]);
    chk("t6_old_a7", rd_got[7], a_pat[7]);

    // Randomized: fill the upper half, then run writes (lower half) and reads (upper half)
    // concurrently, then read the lower half back.
    for (int s = 512; s < D; s += 16) begin
      for (int b = 0; b < 16; b++) begin
        wd[b] = {$urandom, $urandom, $urandom, $urandom}; ws[b] = 16'hFFFF;
      end
      do_write(32'(s) << 4, 15, 3'b100, 2'd1, 0);
    end
    fork
      for (int i = 0; i < 30; i++) rand_write(0, 496);
      for (int i = 0; i < 30; i++) rand_read(512, 512);
    join
    for (int s = 0; s < 496; s += 62) do_read(32'(s) << 4, 15, 3'b100, 2'd1, 2);

    repeat (3) @(negedge clk);
    chk("end_rq_empty", 128'(rq.size()), 128'd0);
    chk("end_bq_empty", 128'(bq.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
